operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 119 +++++++++++
 tb/tb_operand_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard-gated issue, writeback bypass, and a one-deep
// registered operand bundle handed to the downstream stage with valid/ready.
module operand_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [2:0]  issue_sr1_i,
    input  logic [2:0]  issue_sr2_i,
    input  logic        issue_use_sr1_i,
    input  logic        issue_use_sr2_i,
    input  logic [2:0]  issue_dr_i,
    input  logic        issue_wr_dr_i,
    output logic [2:0]  rf_sr1_o,
    output logic [2:0]  rf_sr2_o,
    input  logic [15:0] rf_d1_i,
    input  logic [15:0] rf_d2_i,
    input  logic        wb_en_i,
    input  logic [2:0]  wb_dr_i,
    input  logic [15:0] wb_data_i,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic [15:0] op_a_o,
    output logic [15:0] op_b_o,
    output logic [2:0]  op_dr_o,
    output logic        op_wr_dr_o,
    output logic [7:0]  busy_o,
    output logic        sb_err_o
);

    logic [1:0]  pend_q [8];
    logic [1:0]  pend_d [8];
    logic [7:0]  inc_vec;
    logic [7:0]  dec_vec;
    logic [7:0]  underflow;
    logic        sb_err_q;
    logic        op_valid_q;
    logic [15:0] op_a_q, op_b_q;
    logic [2:0]  op_dr_q;
    logic        op_wr_dr_q;
    logic        fire;
    logic        sr1_free, sr2_free, dr_room, slot_free;
    logic        wb_hits_sr1, wb_hits_sr2, wb_hits_dr;
    logic [15:0] src_a, src_b;

    assign rf_sr1_o = issue_sr1_i;
    assign rf_sr2_o = issue_sr2_i;

    assign wb_hits_sr1 = wb_en_i && (wb_dr_i == issue_sr1_i);
    assign wb_hits_sr2 = wb_en_i && (wb_dr_i == issue_sr2_i);
    assign wb_hits_dr  = wb_en_i && (wb_dr_i == issue_dr_i);

    // A single outstanding write being retired this cycle is covered by the bypass.
    assign sr1_free = (pend_q[issue_sr1_i] == 2'd0) ||
                      ((pend_q[issue_sr1_i] == 2'd1) && wb_hits_sr1);
    assign sr2_free = (pend_q[issue_sr2_i] == 2'd0) ||
                      ((pend_q[issue_sr2_i] == 2'd1) && wb_hits_sr2);
    assign dr_room  = !issue_wr_dr_i || (pend_q[issue_dr_i] != 2'd3) || wb_hits_dr;
    assign slot_free = !op_valid_q || op_ready_i;

    assign issue_ready_o = (!issue_use_sr1_i || sr1_free) &&
                           (!issue_use_sr2_i || sr2_free) &&
                           dr_room && slot_free;
    assign fire = issue_valid_i && issue_ready_o;

    assign src_a = !issue_use_sr1_i ? 16'h0000 : (wb_hits_sr1 ? wb_data_i : rf_d1_i);
    assign src_b = !issue_use_sr2_i ? 16'h0000 : (wb_hits_sr2 ? wb_data_i : rf_d2_i);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pend
            assign inc_vec[gi] = fire && issue_wr_dr_i && (issue_dr_i == gi[2:0]);
            assign dec_vec[gi] = wb_en_i && (wb_dr_i == gi[2:0]);
            assign underflow[gi] = dec_vec[gi] && !inc_vec[gi] && (pend_q[gi] == 2'd0);
            assign pend_d[gi] = (inc_vec[gi] && !dec_vec[gi]) ? pend_q[gi] + 2'd1 :
                                (dec_vec[gi] && !inc_vec[gi] && (pend_q[gi] != 2'd0)) ?
                                    pend_q[gi] - 2'd1 : pend_q[gi];
            assign busy_o[gi] = |pend_q[gi];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pend_q[gi] <= 2'd0;
                end else begin
                    pend_q[gi] <= pend_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_err_q   <= 1'b0;
            op_valid_q <= 1'b0;
            op_a_q     <= 16'h0000;
            op_b_q     <= 16'h0000;
            op_dr_q    <= 3'd0;
            op_wr_dr_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_q || (|underflow);
            if (fire) begin
                op_valid_q <= 1'b1;
                op_a_q     <= src_a;
                op_b_q     <= src_b;
                op_dr_q    <= issue_dr_i;
                op_wr_dr_q <= issue_wr_dr_i;
            end else if (op_ready_i) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    assign op_valid_o = op_valid_q;
    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;
    assign op_dr_o    = op_dr_q;
    assign op_wr_dr_o = op_wr_dr_q;
    assign sb_err_o   = sb_err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic, all checked
// against a behavioural scoreboard/register-file model.
module tb_operand_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i, issue_ready_o;
    logic [2:0]  issue_sr1_i, issue_sr2_i, issue_dr_i;
    logic        issue_use_sr1_i, issue_use_sr2_i, issue_wr_dr_i;
    logic [2:0]  rf_sr1_o, rf_sr2_o;
    logic [15:0] rf_d1_i, rf_d2_i;
    logic        wb_en_i;
    logic [2:0]  wb_dr_i;
    logic [15:0] wb_data_i;
    logic        op_valid_o, op_ready_i;
    logic [15:0] op_a_o, op_b_o;
    logic [2:0]  op_dr_o;
    logic        op_wr_dr_o;
    logic [7:0]  busy_o;
    logic        sb_err_o;

    operand_fetch dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_sr1_i(issue_sr1_i), .issue_sr2_i(issue_sr2_i),
        .issue_use_sr1_i(issue_use_sr1_i), .issue_use_sr2_i(issue_use_sr2_i),
        .issue_dr_i(issue_dr_i), .issue_wr_dr_i(issue_wr_dr_i),
        .rf_sr1_o(rf_sr1_o), .rf_sr2_o(rf_sr2_o),
        .rf_d1_i(rf_d1_i), .rf_d2_i(rf_d2_i),
        .wb_en_i(wb_en_i), .wb_dr_i(wb_dr_i), .wb_data_i(wb_data_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .op_dr_o(op_dr_o), .op_wr_dr_o(op_wr_dr_o),
        .busy_o(busy_o), .sb_err_o(sb_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] rf_mem [8];
    assign rf_d1_i = rf_mem[rf_sr1_o];
    assign rf_d2_i = rf_mem[rf_sr2_o];

    // Reference model
    int          m_pend [8];
    bit          m_err, m_valid, m_wr;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_dr;
    bit          last_ready, last_fire;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_free(input int s);
        return (m_pend[s] == 0) || (m_pend[s] == 1 && wb_en_i && int'(wb_dr_i) == s);
    endfunction

    function automatic bit model_ready();
        bit ok = 1;
        if (issue_use_sr1_i && !src_free(int'(issue_sr1_i))) ok = 0;
        if (issue_use_sr2_i && !src_free(int'(issue_sr2_i))) ok = 0;
        if (m_valid && !op_ready_i) ok = 0;
        if (issue_wr_dr_i && m_pend[issue_dr_i] >= 3 && !(wb_en_i && wb_dr_i == issue_dr_i)) ok = 0;
        return ok;
    endfunction

    function automatic logic [15:0] operand(input logic [2:0] s, input logic use_it);
        if (!use_it) return 16'h0000;
        if (wb_en_i && wb_dr_i == s) return wb_data_i;
        return rf_mem[s];
    endfunction

    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (m_pend[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        m_err = 0; m_valid = 0; m_wr = 0; m_a = 0; m_b = 0; m_dr = 0;
    endtask

    // One clock: called with clk low and inputs already driven.
    task automatic step();
        logic [15:0] na, nb;
        bit inc, dec;
        #1;
        last_ready = model_ready();
        last_fire  = issue_valid_i && last_ready;
        chk("issue_ready", issue_ready_o, last_ready);
        chk("rf_sr1", rf_sr1_o, issue_sr1_i);
        chk("rf_sr2", rf_sr2_o, issue_sr2_i);
        na = operand(issue_sr1_i, issue_use_sr1_i);
        nb = operand(issue_sr2_i, issue_use_sr2_i);
        @(posedge clk_i);
        for (int i = 0; i < 8; i++) begin
            inc = last_fire && issue_wr_dr_i && int'(issue_dr_i) == i;
            dec = wb_en_i && int'(wb_dr_i) == i;
            if (inc && !dec) m_pend[i]++;
            else if (dec && !inc) begin
                if (m_pend[i] == 0) m_err = 1;
                else m_pend[i]--;
            end
        end
        if (last_fire) begin
            m_valid = 1; m_a = na; m_b = nb; m_dr = issue_dr_i; m_wr = issue_wr_dr_i;
        end else if (op_ready_i) m_valid = 0;
        if (wb_en_i) rf_mem[wb_dr_i] = wb_data_i;
        #1;
        chk("op_valid", op_valid_o, m_valid);
        chk("op_a", op_a_o, m_a);
        chk("op_b", op_b_o, m_b);
        chk("op_dr", op_dr_o, m_dr);
        chk("op_wr_dr", op_wr_dr_o, m_wr);
        chk("busy", busy_o, model_busy());
        chk("sb_err", sb_err_o, m_err);
        @(negedge clk_i);
    endtask

    task automatic set_issue(input bit v, input logic [2:0] s1, input bit u1,
                             input logic [2:0] s2, input bit u2,
                             input logic [2:0] d, input bit w);
        issue_valid_i = v; issue_sr1_i = s1; issue_use_sr1_i = u1;
        issue_sr2_i = s2; issue_use_sr2_i = u2; issue_dr_i = d; issue_wr_dr_i = w;
    endtask

    task automatic set_wb(input bit e, input logic [2:0] d, input logic [15:0] v);
        wb_en_i = e; wb_dr_i = d; wb_data_i = v;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'h1000 + 16'(i);
        rst_i = 1'b1;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        op_ready_i = 1'b1;
        model_reset();
        #2;
        chk("rst_op_valid", op_valid_o, 0);
        chk("rst_op_a", op_a_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sb_err", sb_err_o, 0);
        chk("rst_issue_ready", issue_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Plain read of R3
        rf_mem[3] = 16'h1234;
        set_issue(1, 3, 1, 0, 0, 0, 0);
        step();
        chk("r3_fire", last_fire, 1);
        chk("r3_op_a", op_a_o, 16'h1234);
        chk("r3_op_b", op_b_o, 16'h0000);

        // RAW on R2 resolved through writeback bypass
        set_issue(1, 0, 0, 0, 0, 2, 1);
        step();
        chk("r2_busy", busy_o[2], 1);
        set_issue(1, 2, 1, 0, 0, 0, 0);
        step();
        chk("r2_stall", last_fire, 0);
        step();
        chk("r2_stall2", last_fire, 0);
        set_wb(1, 2, 16'hBEEF);
        step();
        chk("r2_bypass_fire", last_fire, 1);
        chk("r2_bypass_a", op_a_o, 16'hBEEF);
        chk("r2_busy_clr", busy_o[2], 0);
        set_wb(0, 0, 0);

        // Counter saturation on R5
        for (int k = 0; k < 3; k++) begin
            set_issue(1, 0, 0, 0, 0, 5, 1);
            step();
            chk("r5_fill", last_fire, 1);
        end
        step();
        chk("r5_full_stall", last_fire, 0);
        set_wb(1, 5, 16'h5555);
        step();
        chk("r5_wb_fire", last_fire, 1);
        set_wb(0, 0, 0);
        step();
        chk("r5_still_full", last_fire, 0);
        set_issue(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            set_wb(1, 5, 16'h5000 + 16'(k));
            step();
        end
        set_wb(0, 0, 0);
        chk("r5_drained", busy_o, 0);

        // Downstream backpressure, then back-to-back fires
        op_ready_i = 1'b0;
        set_issue(1, 1, 1, 4, 1, 6, 0);
        for (int k = 0; k < 4; k++) step();
        chk("bp_stalled", last_fire, 0);
        op_ready_i = 1'b1;
        step();
        chk("bp_fire1", last_fire, 1);
        set_issue(1, 4, 1, 4, 1, 3, 1);
        step();
        chk("bp_fire2", last_fire, 1);
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 3, 16'h3333);
        step();
        set_wb(0, 0, 0);

        // Underflow is sticky; async reset clears mid-cycle
        set_wb(1, 7, 16'h7777);
        step();
        set_wb(0, 0, 0);
        step();
        chk("sb_err_sticky", sb_err_o, 1);
        op_ready_i = 1'b0;
        set_issue(1, 0, 0, 0, 0, 1, 1);
        step();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_op_valid", op_valid_o, 0);
        chk("arst_sb_err", sb_err_o, 0);
        chk("arst_busy", busy_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        op_ready_i = 1'b1;
        set_wb(1, 1, 16'h1111);
        step();
        set_wb(0, 0, 0);
        chk("post_rst_underflow", sb_err_o, 1);

        // Randomized traffic; writebacks only target registers with outstanding writes
        for (int k = 0; k < 300; k++) begin
            int cand [$];
            set_issue($urandom_range(0, 1), 3'($urandom), 1'($urandom), 3'($urandom),
                      1'($urandom), 3'($urandom), 1'($urandom));
            op_ready_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) if (m_pend[i] > 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0)
                set_wb(1, 3'(cand[$urandom_range(0, cand.size() - 1)]), 16'($urandom));
            else
                set_wb(0, 3'($urandom), 16'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
